par2ser_com: RTL and testbench
==============================

# par2ser_com

Parallel-to-serial stage placed directly downstream of the 4:1 byte multiplexer in the PHY transmit path. It consumes one 8-bit word plus valid per byte slot and serializes it MSB-first on a single-bit lane at 8× the byte rate. Invalid slots are replaced with the COM idle symbol. After reset, a training phase forces a minimum run of COM words so the receiver's deserializer can align.

## Interface
Parameters:
- IDLE_SYM, 8'hBC, COM symbol sent on invalid slots and during training.
- MIN_COM, 4, number of COM words forced after reset; legal range 2..15.

Ports:
- clk32f  in  1  bit clock, 8× the byte rate; the only clock.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  8  byte from the upstream mux.
- valid_in  in  1  data_in qualifier.
- byte_tick  out  1  capture strobe; data_in/valid_in are sampled at the rising edge ending a cycle with byte_tick=1.
- data_out  out  1  serial lane, registered.
- active  out  1  training complete, registered.

## Operation
- Registers:
  - bit_cnt[2:0], counts 0..7 and wraps.
  - sr[7:0], shift register.
  - data_out.
  - state ∈ {TRAIN, ACTIVE}.
  - com_cnt[3:0].
  - active.
- Reset (async, reset=0):
  - bit_cnt=0, sr=IDLE_SYM, data_out=0, state=TRAIN, com_cnt=1, active=0.
  - The preloaded sr counts as COM word #1.
- Every edge: data_out <= sr[7]; bit_cnt <= bit_cnt+1 (7→0 wrap).
- Shift vs. capture:
  - If bit_cnt≠7: sr <= {sr[6:0],1'b0}.
  - If bit_cnt==7 (capture edge): sr <= next word.
- byte_tick = (bit_cnt==7), decoded from the counter register.
- Next word:
  - TRAIN: IDLE_SYM regardless of valid_in; com_cnt <= com_cnt+1.
  - ACTIVE: valid_in ? data_in : IDLE_SYM.
- TRAIN→ACTIVE:
  - Happens at the capture edge that loads word #MIN_COM, i.e. when com_cnt==MIN_COM-1 before that edge.
  - active <= 1 on the same edge.
- ACTIVE is absorbing until reset; com_cnt holds in ACTIVE.
- data_in is not checked or altered: a valid byte equal to IDLE_SYM is sent as-is.

## Timing
- Edges are numbered from the first rising edge after reset deasserts (edge 1).
- Capture edges are 8, 16, 24, …; the word loaded at edge 8k appears on data_out after edges 8k+1 (MSB) through 8k+8 (LSB).
- Word #1 (IDLE_SYM) occupies data_out after edges 1..8.
- Latency: data_in sampled at a capture edge → its MSB is on data_out one edge later, its LSB eight edges later.
- With MIN_COM=4:
  - Words 1–4 are COM (data_out after edges 1..32).
  - active rises at edge 24.
  - The first valid-dependent word is captured at edge 32 and its MSB is on data_out after edge 33.
- A valid_in pulse outside the byte_tick cycle is ignored. Upstream must hold data/valid stable across the byte_tick cycle.
- Reset asserted mid-word:
  - All registers take their reset values immediately and the in-flight word is truncated.
  - Training restarts from word #1 after release.
- Back-to-back valid words are sent with no gap.
- valid_in=0 in ACTIVE inserts exactly one COM word per slot.

## Structure
- Shared header phy_defs.vh holds IDLE_SYM default 8'hBC, the TRAIN/ACTIVE state encodings (1'b0/1'b1), and the byte width 8. The deserializer and multiplexer stages include the same file.
- Single module, no sub-module.
- The counter, shifter and FSM are small enough to keep as separate always blocks in one file; the target is about 150 lines.

## Test plan
- Reset then valid_in=1, data_in=8'hA5 held: data_out after edges 1..32 = BC BC BC BC (10111100 ×4). Edges 33..40 = 10100101. active=1 from edge 24.
- ACTIVE, bytes 8'h01, 8'hFF, 8'h80 on consecutive byte_ticks with valid=1: 00000001, 11111111, 10000000 contiguous, no gaps.
- ACTIVE, valid pattern 1,0,1 with data 8'h3C, 8'h55, 8'hC3: lane shows 3C, BC, C3. The 8'h55 is never transmitted.
- During TRAIN, valid_in=1, data_in=8'h12 every slot: words 1–4 are still BC and 8'h12 first appears as word 5.
- Assert reset at bit 3 of an ACTIVE 8'hF0 word:
  - data_out=0, active=0, byte_tick=0 immediately.
  - After release, 4 COM words precede data.
- MIN_COM=2, valid=1, data 8'h77: words 1–2 are BC, active rises at edge 8, and word 3 = 01110111 after edges 17..24.

Source files
------------

// File: rtl/par2ser_com_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : par2ser_com_pkg
//  Description : Shared PHY transmit definitions for the parallel-to-serial
//                stage: byte width, default COM symbol, training length and
//                the TRAIN/ACTIVE state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package par2ser_com_pkg;

  // Width of one lane byte.
  localparam int BYTE_W = 8;

  // Width of the bit-position counter inside one byte.
  localparam int BIT_CNT_W = 3;

  // Last bit position of a byte; the capture edge ends this slot.
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = 3'd7;

  // COM idle symbol used on invalid slots and throughout training.
  localparam logic [BYTE_W-1:0] IDLE_SYM_DEFAULT = 8'hBC;

  // Default number of COM words forced after reset (legal 2..15).
  localparam int unsigned MIN_COM_DEFAULT = 4;

  // Width of the training word counter.
  localparam int COM_CNT_W = 4;

  // Link state: TRAIN until enough COM words are sent, then ACTIVE.
  typedef enum logic {
    ST_TRAIN  = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // True in the last bit slot of a byte, when the next word is captured.
  function automatic logic is_capture(input logic [BIT_CNT_W-1:0] cnt);
    return (cnt == LAST_BIT);
  endfunction

endpackage : par2ser_com_pkg
`default_nettype wire

// File: rtl/par2ser_com.sv
`default_nettype none
// ============================================================================
//  Module      : par2ser_com
//  Description : Parallel-to-serial stage of the PHY transmit path. Captures
//                one byte per byte slot and shifts it out MSB-first at 8x the
//                byte rate. Invalid slots carry the COM idle symbol, and after
//                reset a training run of MIN_COM COM words is forced so the
//                receiver deserializer can find byte alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
module par2ser_com
  import par2ser_com_pkg::*;
#(
  // COM symbol transmitted on invalid slots and during training.
  parameter logic [BYTE_W-1:0] IDLE_SYM = IDLE_SYM_DEFAULT,
  // Number of COM words forced after reset; legal range 2..15.
  parameter int unsigned       MIN_COM  = MIN_COM_DEFAULT
) (
  input  logic              clk32f,     // bit clock, 8x the byte rate
  input  logic              reset,      // asynchronous, active low
  input  logic [BYTE_W-1:0] data_in,    // byte from the upstream mux
  input  logic              valid_in,   // data_in qualifier
  output logic              byte_tick,  // capture strobe for data_in/valid_in
  output logic              data_out,   // registered serial lane
  output logic              active      // registered training-complete flag
);

  // Training ends at the capture edge that loads word #MIN_COM. Word #1 is
  // the reset preload, so the counter already reads MIN_COM-1 at that edge.
  localparam logic [COM_CNT_W-1:0] COM_LAST = COM_CNT_W'(MIN_COM - 1);

  // Reset value of the training counter: the preloaded shift register is
  // already COM word #1.
  localparam logic [COM_CNT_W-1:0] COM_CNT_RST = 4'd1;

  // --------------------------------------------------------------------------
  // Register state
  // --------------------------------------------------------------------------
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    sr_q,      sr_d;
  logic                 data_out_q, data_out_d;
  state_e               state_q,   state_d;
  logic [COM_CNT_W-1:0] com_cnt_q, com_cnt_d;
  logic                 active_q,  active_d;

  // Combinational helpers
  logic                 capture;
  logic [BYTE_W-1:0]    next_word;

  // Capture strobe decoded straight from the counter register.
  always_comb begin
    capture   = is_capture(bit_cnt_q);
    byte_tick = capture;
  end

  // Bit counter advances every edge and wraps from 7 back to 0.
  always_comb begin
    bit_cnt_d = bit_cnt_q + 3'd1;
  end

  // Bit counter register.
  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Select the word to load: COM while training, otherwise the qualified
  // input byte. A valid byte equal to IDLE_SYM is passed through unchanged.
  always_comb begin
    next_word = IDLE_SYM;
    if (state_q == ST_ACTIVE && valid_in) begin
      next_word = data_in;
    end
  end

  // Shift MSB-first on ordinary edges, load the next word on the capture
  // edge so consecutive words follow each other with no gap.
  always_comb begin
    data_out_d = sr_q[BYTE_W-1];
    if (capture) begin
      sr_d = next_word;
    end else begin
      sr_d = {sr_q[BYTE_W-2:0], 1'b0};
    end
  end

  // Shift register and lane output registers.
  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      sr_q       <= IDLE_SYM;
      data_out_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      data_out_q <= data_out_d;
    end
  end

  // Training FSM: count COM words at each capture edge and switch to ACTIVE
  // when the last forced COM word is loaded. ACTIVE holds until reset.
  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    active_d  = active_q;
    case (state_q)
      ST_TRAIN: begin
        if (capture) begin
          com_cnt_d = com_cnt_q + 4'd1;
          if (com_cnt_q == COM_LAST) begin
            state_d  = ST_ACTIVE;
            active_d = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        state_d = ST_ACTIVE;
      end
      default: begin
        state_d = ST_TRAIN;
      end
    endcase
  end

  // FSM state, training counter and active flag registers.
  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_TRAIN;
      com_cnt_q <= COM_CNT_RST;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      com_cnt_q <= com_cnt_d;
      active_q  <= active_d;
    end
  end

  // Drive registered outputs.
  always_comb begin
    data_out = data_out_q;
    active   = active_q;
  end

endmodule : par2ser_com
`default_nettype wire

// File: tb/tb_par2ser_com.sv
`default_nettype none
// ============================================================================
//  Module      : tb_par2ser_com
//  Description : Scoreboard bench for par2ser_com. Two instances (MIN_COM=4
//                and MIN_COM=2) share the same stimulus. The stimulus side
//                pushes the expected serial bits of each captured word; an
//                independent monitor pops and compares one bit per edge and
//                checks active/byte_tick against the edge-number timeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_par2ser_com;

  localparam logic [7:0] IDLE = 8'hBC;
  localparam int MC_A = 4;
  localparam int MC_B = 2;

  logic       clk32f   = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] data_in  = 8'h00;
  logic       valid_in = 1'b0;

  logic tick_a, dout_a, act_a;
  logic tick_b, dout_b, act_b;

  par2ser_com #(.IDLE_SYM(IDLE), .MIN_COM(MC_A)) dut_a (
    .clk32f   (clk32f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .byte_tick(tick_a),
    .data_out (dout_a),
    .active   (act_a)
  );

  par2ser_com #(.IDLE_SYM(IDLE), .MIN_COM(MC_B)) dut_b (
    .clk32f   (clk32f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .byte_tick(tick_b),
    .data_out (dout_b),
    .active   (act_b)
  );

  always #5 clk32f = ~clk32f;

  // Edge number since reset release (edge 1 = first rising edge after it).
  int edge_n;
  always @(posedge clk32f or negedge reset) begin
    if (!reset) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  typedef struct {
    bit       v;
    bit [7:0] d;
  } slot_t;

  bit    exp_a[$];
  bit    exp_b[$];
  slot_t dir_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%b expected=%b edge=%0d time=%0t",
                  name, act, exp, edge_n, $time);
  endtask

  // Word on the lane: the first min_com words after reset are COM, later
  // words are the byte if valid, otherwise COM.
  function automatic bit [7:0] model_word(input int min_com, input int word_no,
                                          input bit v, input bit [7:0] d);
    if (word_no <= min_com) return IDLE;
    return v ? d : IDLE;
  endfunction

  function automatic void push_word(input int which, input bit [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      if (which == 0) exp_a.push_back(w[i]);
      else            exp_b.push_back(w[i]);
    end
  endfunction

  // Monitor: one lane bit per edge, plus active/byte_tick timeline.
  always @(negedge clk32f) begin
    if (!reset) begin
      check("rst_dout_a", dout_a, 1'b0);
      check("rst_act_a",  act_a,  1'b0);
      check("rst_tick_a", tick_a, 1'b0);
      check("rst_dout_b", dout_b, 1'b0);
      check("rst_act_b",  act_b,  1'b0);
    end else begin
      if (exp_a.size() == 0) begin
        n_total++;
        $display("FAIL lane_a: actual=%b expected=<none> edge=%0d", dout_a, edge_n);
      end else begin
        check("lane_a", dout_a, exp_a.pop_front());
      end
      if (exp_b.size() == 0) begin
        n_total++;
        $display("FAIL lane_b: actual=%b expected=<none> edge=%0d", dout_b, edge_n);
      end else begin
        check("lane_b", dout_b, exp_b.pop_front());
      end
      check("active_a", act_a,  edge_n >= 8 * (MC_A - 1));
      check("active_b", act_b,  edge_n >= 8 * (MC_B - 1));
      check("tick_a",   tick_a, (edge_n % 8) == 7);
      check("tick_b",   tick_b, (edge_n % 8) == 7);
    end
  end

  // Drive one cycle per iteration: slot values in the byte_tick cycle, junk
  // everywhere else (which the design must ignore).
  task automatic run_cycles(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk32f);
      #1;
      if ((edge_n % 8) == 7) begin
        slot_t s;
        int    word_no;
        if (dir_q.size() > 0) begin
          s = dir_q.pop_front();
        end else begin
          s.v = ($urandom_range(0, 9) < 7);
          s.d = 8'($urandom);
        end
        valid_in = s.v;
        data_in  = s.d;
        word_no  = (edge_n + 1) / 8 + 1;
        push_word(0, model_word(MC_A, word_no, s.v, s.d));
        push_word(1, model_word(MC_B, word_no, s.v, s.d));
      end else begin
        valid_in = 1'($urandom);
        data_in  = 8'($urandom);
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    check("async_dout_a", dout_a, 1'b0);
    check("async_act_a",  act_a,  1'b0);
    check("async_tick_a", tick_a, 1'b0);
    check("async_dout_b", dout_b, 1'b0);
    check("async_act_b",  act_b,  1'b0);
    exp_a.delete();
    exp_b.delete();
    dir_q.delete();
    push_word(0, IDLE);
    push_word(1, IDLE);
    repeat (2) @(negedge clk32f);
    #2;
    reset = 1'b1;
  endtask

  function automatic void add_dir(input bit v, input bit [7:0] d, input int n);
    slot_t s;
    s.v = v;
    s.d = d;
    for (int i = 0; i < n; i++) dir_q.push_back(s);
  endfunction

  initial begin
    int guard;
    #1;
    apply_reset();

    // A5 held from reset, then contiguous bytes, then a 1/0/1 valid pattern.
    add_dir(1'b1, 8'hA5, 4);
    add_dir(1'b1, 8'h01, 1);
    add_dir(1'b1, 8'hFF, 1);
    add_dir(1'b1, 8'h80, 1);
    add_dir(1'b1, 8'h3C, 1);
    add_dir(1'b0, 8'h55, 1);
    add_dir(1'b1, 8'hC3, 1);
    add_dir(1'b1, IDLE,  1);
    run_cycles(8 * 12);
    run_cycles(8 * 30);

    // Valid data during training must not reach the lane early.
    apply_reset();
    add_dir(1'b1, 8'h12, 6);
    run_cycles(8 * 6);

    // Reset in the middle of an F0 word while ACTIVE.
    add_dir(1'b1, 8'hF0, 3);
    guard = 0;
    do begin
      run_cycles(1);
      guard++;
    end while (!(((edge_n % 8) == 3) && (dir_q.size() <= 1)) && guard < 64);
    if (guard >= 64) begin
      n_total++;
      $display("FAIL midword_wait: actual=timeout required=F0 in flight");
    end
    #2;
    apply_reset();
    add_dir(1'b1, 8'h5A, 5);
    run_cycles(8 * 8);
    run_cycles(8 * 20);

    @(negedge clk32f);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_par2ser_com
`default_nettype wire
